// File: rtl/rng_dispatch.sv
// rng_dispatch
// ------------
// Seeds an external 64-bit keystream generator, keeps a small buffer of
// generated words topped up, and presents them to a consumer as a
// show-ahead FIFO.
//
// Parameters
//   DEPTH        number of buffered 64-bit words (power of two, 2..16)
//
// Ports
//   clk          clock
//   nRST         asynchronous active-low reset
//   seed_start   one-cycle reseed request (accepted in IDLE or RUN only)
//   seed_key     80-bit key, sampled on the accepted seed_start cycle
//   seed_iv      80-bit IV, sampled on the accepted seed_start cycle
//   seed_busy    high from an accepted reseed until the first word is buffered
//   gen_start    one-cycle start pulse to the generator
//   gen_key      key presented to the generator
//   gen_iv       IV presented to the generator
//   gen_enable   advance request to the generator
//   gen_ready    generator ready flag
//   gen_word     registered generator output, word for the pre-advance state
//   rnd_req      consumer pop request
//   rnd_valid    head word available
//   rnd_data     head word (0 when the buffer is empty)
//   health_fail  sticky repetition-test failure (RNG_HEALTH_CHECK_EN only)
//
// Build option
//   RNG_HEALTH_CHECK_EN  when defined, every pushed word is compared with the
//                        previous pushed word since reseed; a repeat raises a
//                        sticky health_fail that blocks output and generation.

module rng_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        seed_start,
  input  logic [79:0] seed_key,
  input  logic [79:0] seed_iv,
  output logic        seed_busy,
  output logic        gen_start,
  output logic [79:0] gen_key,
  output logic [79:0] gen_iv,
  output logic        gen_enable,
  input  logic        gen_ready,
  input  logic [63:0] gen_word,
  input  logic        rnd_req,
  output logic        rnd_valid,
  output logic [63:0] rnd_data
`ifdef RNG_HEALTH_CHECK_EN
  ,
  output logic        health_fail
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEED      = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [79:0]   key_reg;
  logic [79:0]   iv_reg;
  logic          busy_reg;
  logic          inflight_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [63:0]   mem [DEPTH];

  logic          seed_accept;
  logic          push;
  logic          pop;
  logic [CW:0]   fill_level;
  logic          health_block;
  logic          in_run;
  logic          not_empty;

  // Reseed is only honoured once the previous seeding sequence has finished.
  assign seed_accept = seed_start & ((state_reg == IDLE) | (state_reg == RUN));

  assign in_run    = (state_reg == RUN);
  assign not_empty = (count_reg != '0);

  // Buffered words plus the capture already requested from the generator;
  // one spare bit so the sum can never wrap.
  assign fill_level = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};

  // A reseed flushes the buffer, so any capture landing in the same cycle
  // belongs to the old keystream and is dropped.
  assign push = inflight_reg & ~seed_accept;
  assign pop  = rnd_req & rnd_valid & ~seed_accept;

  assign gen_enable = in_run & gen_ready & (fill_level < (CW+1)'(DEPTH)) & ~health_block;
  assign rnd_valid  = in_run & not_empty & ~health_block;
  assign rnd_data   = not_empty ? mem[rd_ptr_reg] : 64'd0;

  assign gen_key   = key_reg;
  assign gen_iv    = iv_reg;
  assign seed_busy = busy_reg;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gen_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (seed_start) begin
          state_next = SEED;
        end
      end
      SEED: begin
        gen_start  = 1'b1;
        state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        // The generator drops ready while it initialises; wait to see that
        // before trusting a high ready again.
        if (!gen_ready) begin
          state_next = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (gen_ready) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (seed_start) begin
          state_next = SEED;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Seed material and busy flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      key_reg  <= '0;
      iv_reg   <= '0;
      busy_reg <= 1'b0;
    end else if (seed_accept) begin
      key_reg  <= seed_key;
      iv_reg   <= seed_iv;
      busy_reg <= 1'b1;
    end else if (push) begin
      busy_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      inflight_reg <= 1'b0;
    end else if (seed_accept) begin
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      // gen_word is registered in the generator, so the word for an enable
      // arrives exactly one cycle later.
      inflight_reg <= gen_enable;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset: occupancy is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= gen_word;
    end
  end

  // ---------------------------------------------------------------------
  // Repetition health test
  // ---------------------------------------------------------------------
`ifdef RNG_HEALTH_CHECK_EN
  logic        health_fail_reg;
  logic        have_prev_reg;
  logic [63:0] prev_word_reg;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      health_fail_reg <= 1'b0;
      have_prev_reg   <= 1'b0;
      prev_word_reg   <= '0;
    end else if (seed_accept) begin
      // The comparison history restarts with the new keystream.
      health_fail_reg <= 1'b0;
      have_prev_reg   <= 1'b0;
    end else if (push) begin
      if (have_prev_reg && (gen_word == prev_word_reg)) begin
        health_fail_reg <= 1'b1;
      end
      prev_word_reg <= gen_word;
      have_prev_reg <= 1'b1;
    end
  end

  assign health_block = health_fail_reg;
  assign health_fail  = health_fail_reg;
`else
  assign health_block = 1'b0;
`endif

endmodule

// File: tb/tb_rng_dispatch.sv
// tb_rng_dispatch
// ---------------
// Directed bench for rng_dispatch (DEPTH = 4). A behavioural generator model
// produces keystream word i as {key[79:48], 32'h0000_1000 + i}, registered on
// each enable, so expected words are known constants per key.
// Define RNG_HEALTH_CHECK_EN to also exercise the repetition test.

module tb_rng_dispatch;

  logic        clk;
  logic        nRST;
  logic        seed_start;
  logic [79:0] seed_key;
  logic [79:0] seed_iv;
  logic        seed_busy;
  logic        gen_start;
  logic [79:0] gen_key;
  logic [79:0] gen_iv;
  logic        gen_enable;
  logic        gen_ready;
  logic [63:0] gen_word;
  logic        rnd_req;
  logic        rnd_valid;
  logic [63:0] rnd_data;
`ifdef RNG_HEALTH_CHECK_EN
  logic        health_fail;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [79:0] KEY1 = 80'h0123_4567_89AB_CDEF_0123;
  localparam logic [79:0] IV1  = 80'h89AB_CDEF_0123_4567_89AB;
  localparam logic [79:0] KEY2 = 80'hFEDC_BA98_7654_3210_FEDC;
  localparam logic [79:0] IV2  = 80'h7654_3210_FEDC_BA98_7654;
  localparam logic [63:0] W1_0 = 64'h01234567_00001000;
  localparam logic [63:0] W2_0 = 64'hFEDCBA98_00001000;
  localparam logic [63:0] W2_1 = 64'hFEDCBA98_00001001;
  localparam logic [63:0] CONST_WORD = 64'hDEADBEEF_00000000;

  rng_dispatch #(.DEPTH(4)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .seed_start (seed_start),
    .seed_key   (seed_key),
    .seed_iv    (seed_iv),
    .seed_busy  (seed_busy),
    .gen_start  (gen_start),
    .gen_key    (gen_key),
    .gen_iv     (gen_iv),
    .gen_enable (gen_enable),
    .gen_ready  (gen_ready),
    .gen_word   (gen_word),
    .rnd_req    (rnd_req),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data)
`ifdef RNG_HEALTH_CHECK_EN
    ,
    .health_fail(health_fail)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: ready drops for a few cycles after start; each enable
  // registers the word for the current index and advances.
  logic [79:0] g_key = '0;
  logic [31:0] g_idx = '0;
  logic [31:0] g_enables = '0;
  logic [2:0]  g_timer = '0;
  logic        g_ready = 1'b1;
  logic [63:0] g_word = '0;
  logic        force_const = 1'b0;

  assign gen_ready = g_ready;
  assign gen_word  = g_word;

  always @(posedge clk) begin
    if (gen_start) begin
      g_ready   <= 1'b0;
      g_timer   <= 3'd3;
      g_idx     <= '0;
      g_enables <= '0;
      g_key     <= gen_key;
    end else if (!g_ready) begin
      if (g_timer == 3'd0) g_ready <= 1'b1;
      else g_timer <= g_timer - 3'd1;
    end else if (gen_enable) begin
      g_word    <= force_const ? CONST_WORD : {g_key[79:48], 32'h0000_1000 + g_idx};
      g_idx     <= g_idx + 32'd1;
      g_enables <= g_enables + 32'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (rnd_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk1(tag, rnd_valid, 1'b1);
  endtask

  task automatic seed(input logic [79:0] k, input logic [79:0] v);
    seed_key   = k;
    seed_iv    = v;
    seed_start = 1'b1;
    step();
    seed_start = 1'b0;
  endtask

  initial begin
    int n;
    nRST       = 1'b0;
    seed_start = 1'b0;
    seed_key   = '0;
    seed_iv    = '0;
    rnd_req    = 1'b0;
    #2;

    // Reset state
    chk1("rst_gen_start", gen_start, 1'b0);
    chk1("rst_gen_enable", gen_enable, 1'b0);
    chk1("rst_rnd_valid", rnd_valid, 1'b0);
    chk1("rst_seed_busy", seed_busy, 1'b0);
    chkw("rst_rnd_data", 80'(rnd_data), 80'd0);
    chkw("rst_gen_key", gen_key, 80'd0);
    step();
    step();
    nRST = 1'b1;
    step();

    // Request with nothing valid has no effect
    rnd_req = 1'b1;
    step();
    chk1("idle_req_valid", rnd_valid, 1'b0);
    rnd_req = 1'b0;

    // Seed from IDLE
    seed(KEY1, IV1);
    chk1("seed_gen_start", gen_start, 1'b1);
    chkw("seed_gen_key", gen_key, KEY1);
    chkw("seed_gen_iv", gen_iv, IV1);
    chk1("seed_busy_rise", seed_busy, 1'b1);
    // seed_start while in SEED is ignored
    seed_key   = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    seed_start = 1'b1;
    step();
    seed_start = 1'b0;
    chk1("seed_gen_start_1cyc", gen_start, 1'b0);
    chkw("ignored_seed_key", gen_key, KEY1);

    n = 0;
    while (gen_enable !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk1("first_enable", gen_enable, 1'b1);
    chk1("first_enable_valid", rnd_valid, 1'b0);
    step();
    chk1("capture_pending_valid", rnd_valid, 1'b0);
    chk1("capture_pending_busy", seed_busy, 1'b1);
    step();
    chk1("first_push_valid", rnd_valid, 1'b1);
    chkw("first_push_data", 80'(rnd_data), 80'(W1_0));
    chk1("busy_fall", seed_busy, 1'b0);

    // Consumer idle: buffer fills to exactly DEPTH
    for (int i = 0; i < 10; i++) step();
    chkw("fill_enables", 80'(g_enables), 80'd4);
    chk1("fill_enable_low", gen_enable, 1'b0);
    chkw("fill_head", 80'(rnd_data), 80'(W1_0));

    // Sustained pop from full: one word per cycle, in generator order
    rnd_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk1($sformatf("stream_valid_%0d", k), rnd_valid, 1'b1);
      chkw($sformatf("stream_data_%0d", k), 80'(rnd_data), 80'(W1_0 + 64'(k)));
      step();
    end
    rnd_req = 1'b0;

    // Reseed during RUN with a capture in flight (enable was high last cycle)
    chk1("pre_reseed_enable", gen_enable, 1'b1);
    step();
    seed(KEY2, IV2);
    chk1("reseed_gen_start", gen_start, 1'b1);
    chk1("reseed_valid", rnd_valid, 1'b0);
    chkw("reseed_flushed_data", 80'(rnd_data), 80'd0);
    chk1("reseed_busy", seed_busy, 1'b1);
    wait_valid("reseed_wait_valid");
    chkw("reseed_first_word", 80'(rnd_data), 80'(W2_0));
    rnd_req = 1'b1;
    step();
    rnd_req = 1'b0;
    chkw("reseed_second_word", 80'(rnd_data), 80'(W2_1));

    // Fill until generation stops (3 buffered + 1 in flight), then reset
    n = 0;
    while (gen_enable !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk1("prefill_enable_low", gen_enable, 1'b0);
    chk1("prefill_valid", rnd_valid, 1'b1);
    #1;
    nRST = 1'b0;
    #1;
    chk1("midrst_valid", rnd_valid, 1'b0);
    chkw("midrst_data", 80'(rnd_data), 80'd0);
    chk1("midrst_enable", gen_enable, 1'b0);
    chk1("midrst_busy", seed_busy, 1'b0);
    chkw("midrst_key", gen_key, 80'd0);
    chkw("midrst_iv", gen_iv, 80'd0);
    step();
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1($sformatf("postrst_valid_%0d", i), rnd_valid, 1'b0);
    end

    // Restart after reset
    seed(KEY1, IV1);
    wait_valid("restart_wait_valid");
    chkw("restart_first_word", 80'(rnd_data), 80'(W1_0));

`ifdef RNG_HEALTH_CHECK_EN
    force_const = 1'b1;
    seed(KEY1, IV1);
    chk1("hc_clear_on_seed", health_fail, 1'b0);
    wait_valid("hc_wait_valid");
    chk1("hc_after_first_push", health_fail, 1'b0);
    chkw("hc_first_word", 80'(rnd_data), 80'(CONST_WORD));
    step();
    chk1("hc_after_second_push", health_fail, 1'b1);
    chk1("hc_valid_blocked", rnd_valid, 1'b0);
    chk1("hc_enable_blocked", gen_enable, 1'b0);
    force_const = 1'b0;
    seed(KEY2, IV2);
    chk1("hc_cleared", health_fail, 1'b0);
    wait_valid("hc_recover_valid");
    chkw("hc_recover_word", 80'(rnd_data), 80'(W2_0));
    chk1("hc_recover_flag", health_fail, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_dispatch.md
RNG_DISPATCH -- requirements
Module: rng_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered 64-bit random words (power of two, 2..16).
REQ-002 SHALL have ports: clk input 1 clock; nRST input 1 reset, asynchronous, active-low.
REQ-003 SHALL have seed_start input 1: one-cycle request to reseed the generator with seed_key/seed_iv.
REQ-004 SHALL have seed_key input 80 and seed_iv input 80, both sampled on the accepted seed_start cycle.
REQ-005 SHALL have seed_busy output 1: high from an accepted seed until the first word is buffered.
REQ-006 SHALL have gen_start output 1, gen_key output 80, gen_iv output 80 and gen_enable output 1, all driving the keystream generator.
REQ-007 SHALL have gen_ready input 1 and gen_word input 64 from the generator; gen_word is registered and reflects the pre-advance generator state.
REQ-008 SHALL have consumer ports rnd_req input 1, rnd_valid output 1 and rnd_data output 64 (show-ahead head word).
REQ-009 SHALL have health_fail output 1, present only under REQ-027.

Function
REQ-010 SHALL implement states IDLE, SEED, WAIT_LOW, WAIT_HIGH and RUN.
REQ-011 IDLE/RUN + seed_start: SHALL latch key/IV into gen_key/gen_iv, flush the FIFO, discard any in-flight capture, and go to SEED.
REQ-012 SEED: SHALL assert gen_start for exactly this one cycle, then go to WAIT_LOW.
REQ-013 WAIT_LOW: SHALL wait for gen_ready==0, then go to WAIT_HIGH (one cycle minimum).
REQ-014 WAIT_HIGH: SHALL wait for gen_ready==1, then go to RUN.
REQ-015 seed_start in SEED/WAIT_LOW/WAIT_HIGH SHALL be ignored.
REQ-016 gen_enable SHALL = (state==RUN) & gen_ready & (count + inflight < DEPTH), where count is buffered words and inflight is the 1-bit pending-capture flag.
REQ-017 inflight SHALL register gen_enable; when inflight==1, gen_word SHALL be pushed into the FIFO in that cycle.
REQ-018 Each gen_enable pulse SHALL yield exactly one pushed word, with a latency of 1 cycle.
REQ-019 rnd_valid SHALL = (state==RUN) & (count>0); a pop SHALL occur on rnd_req & rnd_valid.
REQ-020 rnd_req with rnd_valid==0 SHALL have no effect.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve word order.
REQ-022 Pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH.
REQ-023 seed_busy SHALL rise the cycle after an accepted seed_start and fall the cycle after the first push following reseed.
REQ-024 rnd_data SHALL hold the head word while count>0, and SHALL be 0 when the FIFO is empty.

Reset
REQ-025 On nRST low, SHALL enter IDLE with the FIFO empty and inflight=0.
REQ-026 On nRST low, gen_start, gen_enable, gen_key, gen_iv, rnd_valid, rnd_data, seed_busy and health_fail SHALL all be 0, asynchronously; reset mid-operation SHALL drop buffered words.

Configuration
REQ-027 Macro RNG_HEALTH_CHECK_EN defined SHALL enable a repetition test.
 - Each pushed word is compared with the previous pushed word since reseed.
 - Equality sets a sticky health_fail and forces rnd_valid=0 and gen_enable=0.
 - health_fail is cleared only by reset or an accepted seed_start.
REQ-028 With RNG_HEALTH_CHECK_EN undefined, the health_fail port and comparison logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-029 Reset mid-RUN with 3 words buffered -> all outputs 0 immediately, rnd_valid stays 0 until a new seed completes.
REQ-030 seed_start with key=0x0123..., iv=0x89AB... from IDLE -> gen_start high exactly 1 cycle, gen_key/gen_iv match, first push 1 cycle after the first gen_enable, seed_busy falls the following cycle.
REQ-031 Consumer idle, DEPTH=4 -> exactly 4 gen_enable pulses, count=4, gen_enable held low, no word lost or duplicated versus the generator model.
REQ-032 FIFO full and rnd_req held high every cycle -> one word popped per cycle in generator order; the stream is sustained with no bubbles after the fill.
REQ-033 seed_start during RUN with a capture in flight -> the in-flight word is discarded, and the first rnd_data after reseed equals the first word of the new keystream.
REQ-034 With RNG_HEALTH_CHECK_EN, gen_word forced to a constant 0xDEADBEEF_00000000 -> health_fail=1 after the second push, rnd_valid=0, and both clear on the next seed_start.
